// File: rtl/svc_rv_pkg.sv
// Shared RV32 fetch-stage definitions: NOP encoding, branch opcode and B-immediate decode.
// Used by svc_rv_stage_if and, under SVC_RV_IF_BTFN_EN, by svc_rv_bpred_btfn.
package svc_rv_pkg;

   localparam logic [31:0] RV_NOP        = 32'h0000_0013;
   localparam logic [6:0]  OPCODE_BRANCH = 7'b1100011;

   // Sign-extended B-type immediate; bit 0 is always zero.
   function automatic logic [31:0] imm_b(input logic [31:0] instr);
      return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/svc_rv_bpred_btfn.sv
// Static backward-taken / forward-not-taken predictor for conditional branches.
// Only instantiated when SVC_RV_IF_BTFN_EN is defined.
module svc_rv_bpred_btfn
   import svc_rv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            taken_o,
   output logic [XLEN-1:0] target_o
);

   logic [31:0] imm;

   assign imm      = imm_b(instr_i);
   assign taken_o  = (instr_i[6:0] == OPCODE_BRANCH) && imm[12];
   assign target_o = pc_i + imm;

endmodule

// File: rtl/svc_rv_stage_if.sv
// RV32 instruction-fetch stage: PC, synchronous imem request, one-entry skid and IF/ID register.
// Optional static branch prediction is built when SVC_RV_IF_BTFN_EN is defined.
module svc_rv_stage_if
   import svc_rv_pkg::*;
#(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pc_stall,
   input  logic            if_id_stall,
   input  logic            if_id_flush,
   input  logic            pc_sel,
   input  logic [XLEN-1:0] pc_redirect,
   output logic            imem_ren,
   output logic [XLEN-1:0] imem_raddr,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     instr_id,
   output logic [XLEN-1:0] pc_id,
   output logic [XLEN-1:0] pc_plus4_id,
   output logic            valid_id,
   output logic            predicted_id
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic            req_valid_q, req_valid_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;
   logic            skid_valid_q, skid_valid_d;
   logic [31:0]     skid_instr_q, skid_instr_d;
   logic [XLEN-1:0] skid_pc_q, skid_pc_d;
   logic [31:0]     instr_id_q, instr_id_d;
   logic [XLEN-1:0] pc_id_q, pc_id_d;
   logic [XLEN-1:0] pc_plus4_id_q, pc_plus4_id_d;
   logic            valid_id_q, valid_id_d;
   logic            predicted_id_q, predicted_id_d;

   logic            acc_valid;
   logic [31:0]     acc_instr;
   logic [XLEN-1:0] acc_pc;
   logic            accept;
   logic            pred_taken;

   assign imem_ren   = rst_n & ~pc_stall;
   assign imem_raddr = pc_q;

   // A parked skid entry is older than any live response, so it enters ID first.
   always_comb begin
      acc_valid = req_valid_q;
      acc_instr = imem_rdata;
      acc_pc    = req_pc_q;
      if (skid_valid_q) begin
         acc_valid = 1'b1;
         acc_instr = skid_instr_q;
         acc_pc    = skid_pc_q;
      end
   end

   assign accept = acc_valid & ~if_id_flush & ~if_id_stall;

`ifdef SVC_RV_IF_BTFN_EN
   logic            bp_taken;
   logic [XLEN-1:0] bp_target;

   svc_rv_bpred_btfn #(.XLEN(XLEN)) u_bpred (
      .instr_i  (acc_instr),
      .pc_i     (acc_pc),
      .taken_o  (bp_taken),
      .target_o (bp_target)
   );

   assign pred_taken = accept & bp_taken;
`else
   assign pred_taken = 1'b0;
`endif

   always_comb begin
      pc_d        = pc_q;
      req_pc_d    = pc_q;
      req_valid_d = ~pc_stall & ~pc_sel & ~pred_taken;
      if (pc_sel) begin
         pc_d = pc_redirect;
`ifdef SVC_RV_IF_BTFN_EN
      end else if (pred_taken) begin
         pc_d = bp_target;
`endif
      end else if (!pc_stall) begin
         pc_d = pc_q + XLEN'(4);
      end
   end

   always_comb begin
      skid_valid_d   = skid_valid_q;
      skid_instr_d   = skid_instr_q;
      skid_pc_d      = skid_pc_q;
      instr_id_d     = instr_id_q;
      pc_id_d        = pc_id_q;
      pc_plus4_id_d  = pc_plus4_id_q;
      valid_id_d     = valid_id_q;
      predicted_id_d = predicted_id_q;
      if (if_id_flush) begin
         instr_id_d     = RV_NOP;
         valid_id_d     = 1'b0;
         predicted_id_d = 1'b0;
         skid_valid_d   = 1'b0;
      end else if (if_id_stall) begin
         if (req_valid_q) begin
            skid_valid_d = 1'b1;
            skid_instr_d = imem_rdata;
            skid_pc_d    = req_pc_q;
         end
      end else if (acc_valid) begin
         instr_id_d     = acc_instr;
         pc_id_d        = acc_pc;
         pc_plus4_id_d  = acc_pc + XLEN'(4);
         valid_id_d     = 1'b1;
         predicted_id_d = pred_taken;
         skid_valid_d   = 1'b0;
      end else begin
         instr_id_d     = RV_NOP;
         valid_id_d     = 1'b0;
         predicted_id_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q           <= RESET_PC;
         req_valid_q    <= 1'b0;
         req_pc_q       <= '0;
         skid_valid_q   <= 1'b0;
         skid_instr_q   <= RV_NOP;
         skid_pc_q      <= '0;
         instr_id_q     <= RV_NOP;
         pc_id_q        <= '0;
         pc_plus4_id_q  <= XLEN'(4);
         valid_id_q     <= 1'b0;
         predicted_id_q <= 1'b0;
      end else begin
         pc_q           <= pc_d;
         req_valid_q    <= req_valid_d;
         req_pc_q       <= req_pc_d;
         skid_valid_q   <= skid_valid_d;
         skid_instr_q   <= skid_instr_d;
         skid_pc_q      <= skid_pc_d;
         instr_id_q     <= instr_id_d;
         pc_id_q        <= pc_id_d;
         pc_plus4_id_q  <= pc_plus4_id_d;
         valid_id_q     <= valid_id_d;
         predicted_id_q <= predicted_id_d;
      end
   end

   // The hazard unit holds the PC whenever it stalls IF/ID, so the skid can never overflow.
   skid_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      (if_id_stall && !if_id_flush && req_valid_q) |-> !skid_valid_q);

   assign instr_id     = instr_id_q;
   assign pc_id        = pc_id_q;
   assign pc_plus4_id  = pc_plus4_id_q;
   assign valid_id     = valid_id_q;
   assign predicted_id = predicted_id_q;

endmodule

// File: tb/tb_svc_rv_stage_if.sv
// Bench for svc_rv_stage_if: directed vector table, hand-written corner sequences and random traffic
// checked against a queue-based fetch model; prediction expectations follow SVC_RV_IF_BTFN_EN.
module tb_svc_rv_stage_if;
   import svc_rv_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef SVC_RV_IF_BTFN_EN
   localparam bit BTFN = 1'b1;
`else
   localparam bit BTFN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pc_stall = 1'b0, if_id_stall = 1'b0, if_id_flush = 1'b0, pc_sel = 1'b0;
   logic [31:0] pc_redirect = '0;
   logic        imem_ren;
   logic [31:0] imem_raddr;
   logic [31:0] imem_rdata = '0;
   logic [31:0] instr_id, pc_id, pc_plus4_id;
   logic        valid_id, predicted_id;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   svc_rv_stage_if #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pc_stall     (pc_stall),
      .if_id_stall  (if_id_stall),
      .if_id_flush  (if_id_flush),
      .pc_sel       (pc_sel),
      .pc_redirect  (pc_redirect),
      .imem_ren     (imem_ren),
      .imem_raddr   (imem_raddr),
      .imem_rdata   (imem_rdata),
      .instr_id     (instr_id),
      .pc_id        (pc_id),
      .pc_plus4_id  (pc_plus4_id),
      .valid_id     (valid_id),
      .predicted_id (predicted_id)
   );

   // Memory image: beq x0,x0,-16 wherever addr[7:2]==8 (e.g. 0x20), otherwise addr|0xA000.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (a[7:2] == 6'h08) return 32'hFE00_08E3;
      return a | 32'h0000_A000;
   endfunction

   always @(posedge clk) if (imem_ren) imem_rdata <= memWord(imem_raddr);

   // Reference prediction: conditional branch whose offset is negative.
   function automatic bit isBackBranch(input logic [31:0] i);
      return (i[6:0] == 7'b1100011) && i[31];
   endfunction

   function automatic logic [31:0] branchOffset(input logic [31:0] i);
      int off;
      off = int'({i[31], i[7], i[30:25], i[11:8], 1'b0});
      if (i[31]) off = off - 8192;
      return 32'(off);
   endfunction

   // Model: PC, requests in flight, parked responses and the decode slot.
   logic [31:0] mPc = RESET_PC;
   logic [31:0] mInflight[$];
   logic [31:0] mSkid[$];
   logic [31:0] mInstr = NOP, mIdPc = '0;
   logic        mValid = 1'b0, mPred = 1'b0;

   task automatic modelStep();
      bit          haveResp, have, taken;
      logic [31:0] rpc, src, tgt, issuedPc;
      taken = 1'b0;
      tgt = '0;
      if (!rst_n) begin
         mPc = RESET_PC;
         mInflight.delete();
         mSkid.delete();
         mInstr = NOP; mIdPc = '0; mValid = 1'b0; mPred = 1'b0;
         return;
      end
      haveResp = (mInflight.size() != 0);
      rpc = haveResp ? mInflight[0] : '0;
      issuedPc = mPc;
      if (if_id_flush) begin
         mInstr = NOP; mValid = 1'b0; mPred = 1'b0;
         mSkid.delete();
      end else if (if_id_stall) begin
         if (haveResp) mSkid.push_back(rpc);
      end else begin
         have = 1'b0;
         src = '0;
         if (mSkid.size() != 0) begin
            src = mSkid.pop_front();
            have = 1'b1;
         end else if (haveResp) begin
            src = rpc;
            have = 1'b1;
         end
         if (have) begin
            mInstr = memWord(src); mIdPc = src; mValid = 1'b1;
            taken = BTFN && isBackBranch(mInstr);
            tgt = src + branchOffset(mInstr);
            mPred = taken;
         end else begin
            mInstr = NOP; mValid = 1'b0; mPred = 1'b0;
         end
      end
      mInflight.delete();
      if (pc_sel) mPc = pc_redirect;
      else if (taken) mPc = tgt;
      else if (!pc_stall) mPc = mPc + 32'd4;
      if (!pc_stall && !pc_sel && !taken) mInflight.push_back(issuedPc);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Drive inputs away from the edge, then check the combinational request side.
   task automatic applyStimulus(input bit rst, input bit ps, input bit is, input bit fl,
                                input bit sel, input logic [31:0] redir);
      rst_n = rst; pc_stall = ps; if_id_stall = is; if_id_flush = fl;
      pc_sel = sel; pc_redirect = redir;
      #1;
      check("imem_ren", 32'(imem_ren), 32'(rst && !ps));
      if (rst) check("imem_raddr", imem_raddr, mPc);
   endtask

   // Clock one edge, advance the model and compare the decode-side outputs.
   task automatic checkOutput();
      @(posedge clk);
      modelStep();
      @(negedge clk);
      check("valid_id", 32'(valid_id), 32'(mValid));
      check("instr_id", instr_id, mInstr);
      if (mValid) begin
         check("pc_id", pc_id, mIdPc);
         check("pc_plus4_id", pc_plus4_id, mIdPc + 32'd4);
         check("predicted_id", 32'(predicted_id), 32'(mPred));
      end
   endtask

   task automatic cycle(input bit ps, input bit is, input bit fl, input bit sel, input logic [31:0] redir);
      applyStimulus(1'b1, ps, is, fl, sel, redir);
      checkOutput();
   endtask

   typedef struct {
      bit          ps;
      bit          is;
      logic [31:0] expRaddr;
      bit          expRen;
      logic [31:0] expInstr;
      bit          expValid;
   } vec_t;

   vec_t vecs[10];

   initial begin
      vecs[0] = '{0, 0, 32'h00, 1, NOP,          0};
      vecs[1] = '{0, 0, 32'h04, 1, 32'h0000_A000, 1};
      vecs[2] = '{0, 0, 32'h08, 1, 32'h0000_A004, 1};
      vecs[3] = '{0, 0, 32'h0C, 1, 32'h0000_A008, 1};
      vecs[4] = '{1, 1, 32'h10, 0, 32'h0000_A008, 1};
      vecs[5] = '{1, 1, 32'h10, 0, 32'h0000_A008, 1};
      vecs[6] = '{1, 1, 32'h10, 0, 32'h0000_A008, 1};
      vecs[7] = '{0, 0, 32'h10, 1, 32'h0000_A00C, 1};
      vecs[8] = '{0, 0, 32'h14, 1, 32'h0000_A010, 1};
      vecs[9] = '{0, 0, 32'h18, 1, 32'h0000_A014, 1};

      // Reset state.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      checkOutput();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      checkOutput();
      check("reset_pc_id", pc_id, 32'h0);
      check("reset_predicted", 32'(predicted_id), 32'h0);

      // Streaming from RESET_PC, then a three-cycle stall through the skid.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, vecs[i].ps, vecs[i].is, 1'b0, 1'b0, '0);
         check($sformatf("vec%0d_raddr", i), imem_raddr, vecs[i].expRaddr);
         check($sformatf("vec%0d_ren", i), 32'(imem_ren), 32'(vecs[i].expRen));
         checkOutput();
         check($sformatf("vec%0d_instr", i), instr_id, vecs[i].expInstr);
         check($sformatf("vec%0d_valid", i), 32'(valid_id), 32'(vecs[i].expValid));
      end

      // Redirect with flush: the request issued alongside it never reaches ID.
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
      check("redir_bubble", 32'(valid_id), 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      check("redir_raddr", imem_raddr, 32'h100);
      checkOutput();
      check("redir_killed", 32'(valid_id), 32'h0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
      check("redir_pc_id", pc_id, 32'h100);
      check("redir_instr", instr_id, 32'h0000_A100);

      // Flush while stalled with a full skid: bubble now and an empty skid afterwards.
      cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
      check("flstall_valid", 32'(valid_id), 32'h0);
      check("flstall_instr", instr_id, NOP);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
      check("flstall_skid_empty", 32'(valid_id), 32'h0);

      // Backward branch at 0x20 (imm -16): predicted when the feature is built.
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h18);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
      check("br_pc_id", pc_id, 32'h20);
      check("br_predicted", 32'(predicted_id), 32'(BTFN));
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      check("br_next_raddr", imem_raddr, BTFN ? 32'h10 : 32'h28);
      checkOutput();
      check("br_fallthru_valid", 32'(valid_id), BTFN ? 32'h0 : 32'h1);
      if (!BTFN) check("br_fallthru_pc", pc_id, 32'h24);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);

      // Reset during a stall with the skid full.
      cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      check("rst_mid_ren", 32'(imem_ren), 32'h0);
      checkOutput();
      check("rst_mid_valid", 32'(valid_id), 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      check("rst_mid_first_raddr", imem_raddr, RESET_PC);
      checkOutput();
      check("rst_mid_skid_empty", 32'(valid_id), 32'h0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
      check("rst_mid_first_pc", pc_id, RESET_PC);

      // Random hazard traffic; IF/ID stalls always come with a PC stall.
      for (int n = 0; n < 400; n++) begin
         bit rst, ps, is, fl, sel;
         logic [31:0] redir;
         rst   = ($urandom_range(0, 99) >= 2);
         ps    = ($urandom_range(0, 3) == 0);
         is    = ps && ($urandom_range(0, 1) == 1);
         sel   = ($urandom_range(0, 11) == 0);
         fl    = sel ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
         redir = 32'($urandom_range(0, 255)) << 2;
         applyStimulus(rst, ps, is, fl, sel, redir);
         checkOutput();
      end

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
